// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command opcodes and controller state encoding
package uart_cmd_pkg;
  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;
endpackage

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART write/read commands into register-file strobes and returns read data
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR
);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  // cnt counts completed RD_WAIT edges; the RD_TIMEOUT-th one aborts unless RdData_Valid arrives on it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      cnt       <= '0;
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
      case (state)
        IDLE: if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(WR_CMD)) state <= WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(RD_CMD)) state <= RD_ADDR;
          else CMD_ERR <= 1'b1;
        end
        WR_ADDR: if (RX_D_VLD) begin
          Address <= RX_P_DATA[ADDR_WIDTH-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          WrData <= RX_P_DATA;
          WrEn   <= 1'b1;
          state  <= IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          Address <= RX_P_DATA[ADDR_WIDTH-1:0];
          RdEn    <= 1'b1;
          cnt     <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (RX_D_VLD) CMD_ERR <= 1'b1;
          if (RdData_Valid) begin
            TX_P_DATA <= RdData;
            state     <= TX_SEND;
          end else if (cnt == CNT_LAST) begin
            CMD_ERR <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_SEND: begin
          if (RX_D_VLD) CMD_ERR <= 1'b1;
          if (!TX_BUSY) begin
            TX_D_VLD <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller that sits directly downstream of the UART receiver and upstream of the UART transmitter in the system clock domain. It consumes received bytes (parallel data plus a one-cycle valid), decodes a 2/3-byte command protocol, and issues register-file writes and reads. Read data is returned to the UART transmitter as a single byte under a busy/valid handshake.

## Interface
- DATA_WIDTH, 8, width of UART bytes and register data
- ADDR_WIDTH, 4, register-file address width (low bits of the address byte)
- RD_TIMEOUT, 15, cycles to wait for RdData_Valid after RdEn before aborting

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte from UART RX
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- WrEn  out  1  register-file write strobe, one cycle
- RdEn  out  1  register-file read strobe, one cycle
- Address  out  ADDR_WIDTH  register address
- WrData  out  DATA_WIDTH  register write data
- RdData  in  DATA_WIDTH  register read data
- RdData_Valid  in  1  one-cycle pulse, RdData valid
- TX_P_DATA  out  DATA_WIDTH  byte to UART TX
- TX_D_VLD  out  1  one-cycle pulse, TX_P_DATA valid
- TX_BUSY  in  1  UART TX busy (already synchronised into CLK)
- CMD_ERR  out  1  one-cycle pulse on protocol error

## Operation
- Commands: 0xAA = write (AA, addr, data); 0xBB = read (BB, addr) -> one response byte.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE: RX_D_VLD with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> CMD_ERR pulse, stay IDLE.
- WR_ADDR: byte latched to Address (low ADDR_WIDTH bits) -> WR_DATA.
- WR_DATA: byte latched to WrData, WrEn pulsed -> IDLE.
- RD_ADDR: byte latched to Address, RdEn pulsed, timeout counter cleared -> RD_WAIT.
- RD_WAIT: RdData_Valid -> RdData latched to TX_P_DATA -> TX_SEND; counter reaching RD_TIMEOUT -> CMD_ERR pulse -> IDLE.
- TX_SEND: first cycle with TX_BUSY=0 -> TX_D_VLD pulse -> IDLE.
- RX_D_VLD while in RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse, state unchanged.
- RdData_Valid outside RD_WAIT: ignored.
- Address upper bits beyond ADDR_WIDTH silently discarded.

## Timing
- Reset (RST=0, async): state IDLE; WrEn, RdEn, TX_D_VLD, CMD_ERR = 0; Address, WrData, TX_P_DATA = 0; counter = 0.
- All outputs registered. Byte accepted on edge where RX_D_VLD=1.
- Write: data byte accepted at edge k -> WrEn=1 with stable Address/WrData during cycle k+1 only; state IDLE at k+1, a new 0xAA/0xBB at edge k+1 is accepted.
- Read: address byte at edge m -> RdEn=1 during cycle m+1 only; RdData_Valid at edge p -> TX_P_DATA valid from p+1 and held until next read; TX_D_VLD high in the first cycle ≥ p+1 where TX_BUSY=0 (same cycle if TX_BUSY already 0 at p+1... evaluated registered: pulse in cycle after TX_BUSY sampled 0).
- Timeout: counter increments each RD_WAIT cycle; abort when count == RD_TIMEOUT without RdData_Valid; RdData_Valid on that same edge wins (read completes).
- CMD_ERR: exactly one cycle per error event.
- Reset mid-command or during TX_SEND: command and pending response abandoned, no TX_D_VLD.

## Structure
- Package uart_cmd_pkg: WR_CMD=8'hAA, RD_CMD=8'hBB, state enumeration encoding.
- Single module; timeout counter inline (≤4 bits for default), no sub-module.

## Test plan
- Write: RX bytes AA, 05, 3C -> one-cycle WrEn with Address=5, WrData=0x3C; no TX_D_VLD.
- Read: RX BB, 05; model returns RdData=0x3C one cycle after RdEn -> TX_P_DATA=0x3C, single TX_D_VLD pulse.
- Backpressure: read with TX_BUSY=1 for 20 cycles -> TX_D_VLD withheld, pulses once in first cycle after TX_BUSY falls.
- Errors: RX byte 0x55 in IDLE -> CMD_ERR pulse, stays IDLE; read with no RdData_Valid -> CMD_ERR after 15 cycles, next AA accepted.
- Busy drop: RX byte during RD_WAIT -> CMD_ERR, read still completes with correct data.
- Reset mid-write (after AA, 05, RST low) -> all outputs 0, following data byte treated as new command (error if not AA/BB).
